// File: rtl/zigzag_block_buffer_pkg.sv
// Shared constants, types and zigzag tables
// for the streaming zigzag block buffer.
package zigzag_block_buffer_pkg;

  localparam int BLK    = 64;
  localparam int COEF_W = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic {
    WR_IDLE,
    WR_FILL
  } wr_state_e;

  // zigzag index -> raster index
  localparam logic [5:0] ZR_LUT [BLK] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };

  // raster index -> zigzag index
  localparam logic [5:0] RZ_LUT [BLK] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

  // mode 0: decode (zz -> raster)
  // mode 1: encode (raster -> zz)
  function automatic logic [5:0] zz_map(
    input logic [5:0] idx,
    input logic       mode
  );
    return mode ? RZ_LUT[idx] : ZR_LUT[idx];
  endfunction

endpackage

// File: rtl/zigzag_block_buffer_if.sv
// Coefficient stream in / parallel block out.
// master = producer+consumer side, slave = buffer.
interface zigzag_block_buffer_if
  import zigzag_block_buffer_pkg::*;
#(
  parameter int W = 16
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [W-1:0]     in_coef;
  logic                    in_eob;
  logic                    in_mode;

  logic                    out_valid;
  logic                    out_ready;
  logic [BLK-1:0][W-1:0]   out_block;
  logic [6:0]              out_ncoef;

  modport master (
    output in_valid,
    output in_coef,
    output in_eob,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_block,
    input  out_ncoef
  );

  modport slave (
    input  in_valid,
    input  in_coef,
    input  in_eob,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_block,
    output out_ncoef
  );

endinterface

// File: rtl/zigzag_block_buffer_zz_addr_map.sv
// Stream index + mode -> in-block store address.
// Ports: idx_i, mode_i in; addr_o out (combinational).
module zz_addr_map
  import zigzag_block_buffer_pkg::*;
(
  input  logic [5:0] idx_i,
  input  logic       mode_i,
  output logic [5:0] addr_o
);

  assign addr_o = zz_map(idx_i, mode_i);

endmodule

// File: rtl/zigzag_block_buffer.sv
// NBUF-deep ping-pong 8x8 block store with zigzag scatter.
// Ports: clk, reset (sync, active-low), bus (slave).
module zigzag_block_buffer
  import zigzag_block_buffer_pkg::*;
#(
  parameter int W    = 16,
  parameter int NBUF = 2
) (
  input  logic clk,
  input  logic reset,
  zigzag_block_buffer_if.slave bus
);

  localparam int PW = (NBUF > 1) ? $clog2(NBUF) : 1;

  typedef logic [PW-1:0] ptr_t;

  wr_state_e        state_q;
  logic [5:0]       wr_idx_q;
  ptr_t             wr_ptr_q;
  ptr_t             rd_ptr_q;
  logic [NBUF-1:0]  full_q;
  logic [NBUF-1:0]  mode_q;
  logic [BLK-1:0]   mask_q  [NBUF];
  logic [6:0]       ncoef_q [NBUF];
  logic [W-1:0]     data_q  [NBUF][BLK];

  logic       wr_fire;
  logic       wr_last;
  logic       wr_first;
  logic       rd_fire;
  logic       map_mode;
  logic [5:0] wr_addr;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(NBUF - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Mode is taken live on the first coef,
  // then from the per-buffer latch.
  assign wr_first = (state_q == WR_IDLE);
  assign map_mode = wr_first ? bus.in_mode
                             : mode_q[wr_ptr_q];

  zz_addr_map u_map (
    .idx_i  (wr_idx_q),
    .mode_i (map_mode),
    .addr_o (wr_addr)
  );

  assign bus.in_ready = reset & ~full_q[wr_ptr_q];
  assign wr_fire      = bus.in_valid & bus.in_ready;
  assign wr_last      = bus.in_eob | (wr_idx_q == 6'd63);

  assign bus.out_valid = full_q[rd_ptr_q];
  assign rd_fire       = bus.out_valid & bus.out_ready;

  always_comb begin
    bus.out_ncoef = '0;
    bus.out_block = '0;
    if (full_q[rd_ptr_q]) begin
      bus.out_ncoef = ncoef_q[rd_ptr_q];
      for (int k = 0; k < BLK; k++) begin
        if (mask_q[rd_ptr_q][k]) begin
          bus.out_block[k] = data_q[rd_ptr_q][k];
        end
      end
    end
  end

  // A write only targets a non-full buffer and a
  // release only a full one, so they never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= WR_IDLE;
      wr_idx_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= '0;
      mode_q   <= '0;
      for (int b = 0; b < NBUF; b++) begin
        mask_q[b]  <= '0;
        ncoef_q[b] <= '0;
      end
    end else begin
      if (wr_fire) begin
        mask_q[wr_ptr_q][wr_addr] <= 1'b1;
        if (wr_first) begin
          mode_q[wr_ptr_q] <= bus.in_mode;
        end
        if (wr_last) begin
          full_q[wr_ptr_q]  <= 1'b1;
          ncoef_q[wr_ptr_q] <= {1'b0, wr_idx_q} + 7'd1;
          wr_idx_q          <= '0;
          wr_ptr_q          <= ptr_inc(wr_ptr_q);
          state_q           <= WR_IDLE;
        end else begin
          wr_idx_q <= wr_idx_q + 6'd1;
          state_q  <= WR_FILL;
        end
      end
      if (rd_fire) begin
        full_q[rd_ptr_q] <= 1'b0;
        mask_q[rd_ptr_q] <= '0;
        rd_ptr_q         <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Payload needs no reset: the masks gate it.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      data_q[wr_ptr_q][wr_addr] <= bus.in_coef;
    end
  end

endmodule

// File: tb/tb_zigzag_block_buffer.sv
// Randomised bench for zigzag_block_buffer
// against a diagonal-walk zigzag model.
module tb_zigzag_block_buffer;
  import zigzag_block_buffer_pkg::*;

  localparam int W    = 16;
  localparam int NBUF = 2;

  typedef logic signed [W-1:0] cv_t;
  typedef struct {
    cv_t v [64];
    int  n;
  } blk_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  int   zz2r [64];
  int   r2zz [64];
  blk_t expq [$];
  bit   rnd_rdy = 1'b0;

  zigzag_block_buffer_if #(.W(W)) bus ();

  zigzag_block_buffer #(
    .W    (W),
    .NBUF (NBUF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string  tag,
    input longint got,
    input longint exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  function automatic blk_t model(
    input cv_t  c [64],
    input int   n,
    input logic md
  );
    blk_t e;
    for (int k = 0; k < 64; k++) e.v[k] = '0;
    for (int i = 0; i < n; i++) begin
      e.v[md ? r2zz[i] : zz2r[i]] = c[i];
    end
    e.n = n;
    return e;
  endfunction

  // consumer-side scoreboard
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      blk_t e;
      check("q_nonempty",
            longint'(expq.size() != 0), 1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        check("ncoef", bus.out_ncoef, e.n);
        for (int k = 0; k < 64; k++) begin
          check("blk", $signed(bus.out_block[k]),
                e.v[k]);
        end
      end
    end
  end

  task automatic tick();
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_block(
    input cv_t  c [64],
    input int   n,
    input logic md,
    input bit   complete,
    input bit   gaps
  );
    for (int i = 0; i < n; i++) begin
      bit lst;
      int t;
      lst = complete && (i == n - 1);
      t   = 0;
      bus.in_valid = 1'b1;
      bus.in_coef  = c[i];
      bus.in_mode  = (i == 0) ? md
                   : 1'($urandom_range(0, 1));
      bus.in_eob   = lst &&
        (n < 64 || $urandom_range(0, 1) == 1);
      forever begin
        @(negedge clk);
        if (bus.in_ready) break;
        if (t > 3000) begin
          check("in_ready_wait", bus.in_ready, 1);
          break;
        end
        t++;
        @(posedge clk); #1;
        tick();
      end
      if (lst) expq.push_back(model(c, n, md));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_eob   = 1'b0;
      tick();
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          tick();
        end
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    while (expq.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    check("drain_empty", expq.size(), 0);
  endtask

  initial begin
    cv_t c [64];
    int  idx;
    idx = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 8) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz2r[idx] = r * 8 + (s - r);
          idx++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz2r[idx] = r * 8 + (s - r);
          idx++;
        end
      end
    end
    for (int i = 0; i < 64; i++) r2zz[zz2r[i]] = i;

    bus.in_valid  = 1'b0;
    bus.in_coef   = '0;
    bus.in_eob    = 1'b0;
    bus.in_mode   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ncoef", bus.out_ncoef, 0);
    check("rst_block_zero",
          longint'(|bus.out_block), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // decode ramp
    bus.out_ready = 1'b1;
    for (int k = 0; k < 64; k++) c[k] = cv_t'(k);
    send_block(c, 64, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("dec_valid_lat", bus.out_valid, 1);
    check("dec_b0", $signed(bus.out_block[0]), 0);
    check("dec_b1", $signed(bus.out_block[1]), 1);
    check("dec_b8", $signed(bus.out_block[8]), 2);
    check("dec_b16", $signed(bus.out_block[16]), 3);
    check("dec_b9", $signed(bus.out_block[9]), 4);
    check("dec_b63", $signed(bus.out_block[63]), 63);
    check("dec_ncoef", bus.out_ncoef, 64);
    @(posedge clk); #1;
    drain();

    // early EOB with zero-fill
    for (int k = 0; k < 64; k++) c[k] = cv_t'(99);
    send_block(c, 64, 1'b0, 1'b1, 1'b0);
    c[0] = cv_t'(10);
    c[1] = cv_t'(-5);
    c[2] = cv_t'(7);
    send_block(c, 3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("eob_valid", bus.out_valid, 1);
    check("eob_b0", $signed(bus.out_block[0]), 10);
    check("eob_b1", $signed(bus.out_block[1]), -5);
    check("eob_b8", $signed(bus.out_block[8]), 7);
    check("eob_b2", $signed(bus.out_block[2]), 0);
    check("eob_ncoef", bus.out_ncoef, 3);
    @(posedge clk); #1;
    drain();

    // encode ramp
    for (int k = 0; k < 64; k++) c[k] = cv_t'(k);
    send_block(c, 64, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("enc_b2", $signed(bus.out_block[2]), 8);
    check("enc_b3", $signed(bus.out_block[3]), 16);
    check("enc_b5", $signed(bus.out_block[5]), 2);
    check("enc_b63", $signed(bus.out_block[63]), 63);
    @(posedge clk); #1;
    drain();

    // per-buffer mode, both held
    bus.out_ready = 1'b0;
    send_block(c, 64, 1'b0, 1'b1, 1'b0);
    send_block(c, 64, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("mode_full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    drain();

    // backpressure
    bus.out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 64; k++) c[k] = cv_t'($urandom);
      send_block(c, 64, 1'($urandom_range(0, 1)),
                 1'b1, 1'b0);
    end
    @(negedge clk);
    check("bp_in_ready_128", bus.in_ready, 0);
    check("bp_out_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_coef  = cv_t'(1234);
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_freed", bus.in_ready, 1);
    check("bp_next_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    for (int k = 0; k < 64; k++) c[k] = cv_t'($urandom);
    send_block(c, 64, 1'b0, 1'b1, 1'b0);
    drain();

    // reset mid-block
    for (int k = 0; k < 64; k++) c[k] = cv_t'(500 + k);
    send_block(c, 20, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_ncoef", bus.out_ncoef, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 64; k++) c[k] = cv_t'(k);
    send_block(c, 64, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("rst2_b8", $signed(bus.out_block[8]), 2);
    check("rst2_b63", $signed(bus.out_block[63]), 63);
    check("rst2_ncoef", bus.out_ncoef, 64);
    @(posedge clk); #1;
    drain();

    // random traffic
    rnd_rdy = 1'b1;
    for (int b = 0; b < 12; b++) begin
      int n;
      n = ($urandom_range(0, 2) == 0) ? 64
        : $urandom_range(1, 64);
      for (int k = 0; k < 64; k++) c[k] = cv_t'($urandom);
      send_block(c, n, 1'($urandom_range(0, 1)),
                 1'b1, 1'b1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
